// File: rtl/sum_to_bcd.sv
// Serial binary-to-BCD converter (shift-and-add-3) for small adder sums.
// Accepts one value at a time and presents the two BCD digits until consumed.
module sum_to_bcd #(
  parameter int IN_W = 5
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [IN_W-1:0] SUM,
  input  logic            IN_VALID,
  output logic            IN_READY,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic [3:0]      TENS,
  output logic [3:0]      ONES,
  output logic            BUSY
);

  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [IN_W-1:0]  bin_q;
  logic [3:0]       tens_q;
  logic [3:0]       ones_q;
  logic [CNT_W-1:0] count_q;
  logic             rst_done_q;

  logic             accept;
  logic             last_shift;
  logic [2:0]       tens_adj;
  logic [3:0]       ones_adj;
  logic [3:0]       tens_shift;
  logic [3:0]       ones_shift;
  logic [IN_W-1:0]  bin_shift;

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  // With at most 63 the tens digit never exceeds 6, so its top bit never shifts out.
  always_comb begin
    tens_adj = 3'(add3(tens_q));
    ones_adj = add3(ones_q);
    {tens_shift, ones_shift, bin_shift} = {tens_adj, ones_adj, bin_q, 1'b0};
  end

  assign IN_READY   = (state == IDLE) && rst_done_q && RST_N;
  assign BUSY       = (state == SHIFT);
  assign OUT_VALID  = (state == DONE);
  assign accept     = IN_VALID && IN_READY;
  assign last_shift = (state == SHIFT) && (count_q == CNT_W'(1));

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = SHIFT;
      SHIFT:   if (last_shift) state_next = DONE;
      DONE:    if (OUT_READY) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Result digits are only loaded on the final shift, so they hold through IDLE/SHIFT.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      bin_q      <= '0;
      tens_q     <= '0;
      ones_q     <= '0;
      count_q    <= '0;
      TENS       <= '0;
      ONES       <= '0;
      rst_done_q <= 1'b0;
    end else begin
      rst_done_q <= 1'b1;
      if (accept) begin
        bin_q   <= SUM;
        tens_q  <= '0;
        ones_q  <= '0;
        count_q <= CNT_W'(IN_W);
      end else if (state == SHIFT) begin
        bin_q   <= bin_shift;
        tens_q  <= tens_shift;
        ones_q  <= ones_shift;
        count_q <= count_q - CNT_W'(1);
        if (last_shift) begin
          TENS <= tens_shift;
          ONES <= ones_shift;
        end
      end
    end
  end

  a_digits_bcd: assert property (@(posedge CLK) disable iff (!RST_N)
    OUT_VALID |-> (TENS <= 4'd9 && ONES <= 4'd9));

  a_hold_result: assert property (@(posedge CLK) disable iff (!RST_N)
    (OUT_VALID && !OUT_READY) |=> (OUT_VALID && $stable(TENS) && $stable(ONES)));

endmodule

// File: doc/sum_to_bcd.md
SUM_TO_BCD -- requirements
Module: sum_to_bcd

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-low.
REQ-002 Parameter IN_W, default 5, SHALL give the binary input width; legal range 1..6, so the maximum value 63 fits in two BCD digits.
REQ-003 Port CLK  input  1  SHALL be the sole clock; all state updates on its rising edge.
REQ-004 Port RST_N  input  1  SHALL be the synchronous active-low reset, sampled on the rising edge of CLK.
REQ-005 Port SUM  input  IN_W  SHALL carry the unsigned binary value to convert, i.e. the 5-bit sum including carry-out from the 4-bit adder stage.
REQ-006 Port IN_VALID  input  1  SHALL indicate that SUM holds a value to convert.
REQ-007 Port IN_READY  output  1  SHALL indicate that the block can accept SUM this cycle.
REQ-008 Port OUT_VALID  output  1  SHALL indicate that TENS and ONES hold a completed result.
REQ-009 Port OUT_READY  input  1  SHALL indicate that the consumer takes the result this cycle.
REQ-010 Port TENS  output  4  SHALL carry the BCD tens digit of the last result.
REQ-011 Port ONES  output  4  SHALL carry the BCD ones digit of the last result.
REQ-012 Port BUSY  output  1  SHALL be high while a conversion is in the SHIFT state.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, SHIFT and DONE.
REQ-014 IN_READY SHALL be 1 only in IDLE; BUSY SHALL be 1 only in SHIFT; OUT_VALID SHALL be 1 only in DONE.
REQ-015 Input handshake: when IN_VALID and IN_READY are both 1 at an edge, the block SHALL capture SUM into an internal shift register, clear the BCD working digits, load the iteration counter with IN_W and move to SHIFT.
REQ-016 The block SHALL ignore SUM and IN_VALID outside the input handshake; changes to SUM after capture SHALL NOT affect the result.
REQ-017 In SHIFT, each cycle the block SHALL add 3 to every working digit that is >= 5, then shift {digits, binary} left by one bit, then decrement the counter.
REQ-018 After the IN_W-th shift the block SHALL load TENS and ONES from the working digits and move to DONE.
REQ-019 Latency: OUT_VALID SHALL rise exactly IN_W cycles after the accepting edge (5 cycles at the default).
REQ-020 TENS and ONES SHALL change only on entry to DONE and SHALL otherwise hold the previous result, including throughout IDLE and SHIFT.
REQ-021 In DONE, TENS, ONES and OUT_VALID SHALL stay stable until OUT_READY is 1; at that edge the block SHALL move to IDLE.
REQ-022 If OUT_READY is already 1 in the first DONE cycle, the block SHALL consume the result at that edge and hold OUT_VALID for exactly one cycle.
REQ-023 Throughput: at most one conversion SHALL be in flight, and the next input SHALL be accepted no earlier than the cycle after the output handshake.
REQ-024 Every result SHALL satisfy TENS*10 + ONES == captured SUM, with each digit in 0..9.

Reset
REQ-025 While RST_N is 0 at an edge, the FSM SHALL go to IDLE and TENS, ONES, OUT_VALID, BUSY, the counter and the working registers SHALL clear to 0.
REQ-026 While RST_N is 0, IN_READY SHALL be 0; it SHALL become 1 in the first cycle after RST_N has been sampled as 1.
REQ-027 A reset during SHIFT or DONE SHALL discard the conversion, and the discarded result SHALL never appear on TENS or ONES.

Verification
REQ-028 The bench SHALL cover: SUM=0 accepted -> OUT_VALID 5 cycles later with TENS=0, ONES=0.
REQ-029 The bench SHALL cover: SUM=31 -> TENS=3, ONES=1; SUM=19 -> TENS=1, ONES=9; SUM=10 -> TENS=1, ONES=0.
REQ-030 The bench SHALL cover backpressure: OUT_READY held 0 for 10 cycles after SUM=27 -> OUT_VALID=1 and TENS=2/ONES=7 stable throughout, IN_READY=0, and a new IN_VALID with SUM=5 ignored.
REQ-031 The bench SHALL cover reset mid-operation: RST_N=0 on the third SHIFT cycle of SUM=29 -> next cycle TENS=0, ONES=0, OUT_VALID=0, IN_READY=0, and no 2/9 result ever appears.
REQ-032 The bench SHALL cover an exhaustive sweep of SUM=0..31 driven from the 4-bit adder outputs with OUT_READY tied to 1 -> every result matches REQ-024 and each OUT_VALID pulse lasts one cycle.
